// File: rtl/gpio_input_capture.sv
// Board switch input capture: 2-flop sync, tick-paced debounce, press detection,
// sticky pending flags and an event counter, packed into the SoC gpI1 input word.

module gpio_input_capture_lane #(
    parameter int STABLE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic sync_i,
    input  logic clr_i,
    output logic state_o,
    output logic pending_o,
    output logic rise_o
);
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          pend_q, pend_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_o  = 1'b0;
        if (tick_i) begin
            if (sync_i == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                state_d = sync_i;
                cnt_d   = '0;
                rise_o  = sync_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // A rise on the same cycle as a clear keeps the flag set.
        pend_d = rise_o | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign state_o   = state_q;
    assign pending_o = pend_q;
endmodule

module gpio_input_capture #(
    parameter int N_SW   = 4,
    parameter int DIV    = 100000,
    parameter int STABLE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_SW-1:0] clr,
    output logic [N_SW-1:0] sw_state,
    output logic [N_SW-1:0] pending,
    output logic [7:0]      evt_cnt,
    output logic [31:0]     gp_word
);
    localparam int PCW = $clog2(DIV);
    localparam logic [PCW-1:0] PC_MAX = PCW'(DIV - 1);

    logic [N_SW-1:0] sync1_q, sync2_q;
    logic [PCW-1:0]  pc_q, pc_d;
    logic            tick;
    logic [N_SW-1:0] rise;
    logic [7:0]      n_rise;
    logic [7:0]      evt_q, evt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    assign tick = (pc_q == PC_MAX);
    assign pc_d = tick ? '0 : pc_q + PCW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    for (genvar i = 0; i < N_SW; i++) begin : gen_lane
        gpio_input_capture_lane #(.STABLE(STABLE)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (tick),
            .sync_i    (sync2_q[i]),
            .clr_i     (clr[i]),
            .state_o   (sw_state[i]),
            .pending_o (pending[i]),
            .rise_o    (rise[i])
        );
    end

    // Simultaneous presses all count, so add the popcount rather than 1.
    always_comb begin
        n_rise = '0;
        for (int i = 0; i < N_SW; i++) n_rise = n_rise + 8'(rise[i]);
        evt_d = evt_q + n_rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) evt_q <= '0;
        else        evt_q <= evt_d;
    end

    assign evt_cnt = evt_q;

    always_comb begin
        gp_word              = '0;
        gp_word[N_SW-1:0]    = sw_state;
        gp_word[8 +: N_SW]   = pending;
        gp_word[23:16]       = evt_q;
    end
endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture with DIV=4, STABLE=3, N_SW=4.
module tb_gpio_input_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  sw_raw = '0;
    logic [3:0]  clr = '0;
    logic [3:0]  sw_state, pending;
    logic [7:0]  evt_cnt;
    logic [31:0] gp_word;
    int checks = 0;
    int errors = 0;

    gpio_input_capture #(.N_SW(4), .DIV(4), .STABLE(3)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .clr(clr),
        .sw_state(sw_state), .pending(pending), .evt_cnt(evt_cnt), .gp_word(gp_word)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts edges until (sw_state & mask) == val; 999 if it never happens.
    task automatic wait_state(input logic [3:0] mask, input logic [3:0] val, output int n);
        n = 999;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if ((sw_state & mask) == val) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] raw);
        sw_raw = raw;
        clr    = '0;
        reset  = 1'b0;
        step(3);
        reset  = 1'b1;
    endtask

    task automatic test_reset;
        int n;
        sw_raw = 4'hF;
        reset  = 1'b0;
        step(5);
        checks++;
        if (gp_word !== 32'h0) begin
            errors++; $display("FAIL reset_gp_word: got %h want %h", gp_word, 32'h0);
        end
        reset = 1'b1;
        wait_state(4'hF, 4'hF, n);
        checks++;
        if (n > 14) begin
            errors++; $display("FAIL reset_release_latency: got %0d want <=14", n);
        end
        checks++;
        if (gp_word !== 32'h0004_0F0F) begin
            errors++; $display("FAIL reset_release_word: got %h want %h", gp_word, 32'h0004_0F0F);
        end
    endtask

    task automatic test_clean_press;
        int n;
        do_reset(4'h0);
        step(2);
        sw_raw[0] = 1'b1;
        wait_state(4'h1, 4'h1, n);
        checks++;
        if (n < 11 || n > 14) begin
            errors++; $display("FAIL press_latency: got %0d want 11..14", n);
        end
        checks++;
        if (pending !== 4'h1 || evt_cnt !== 8'd1) begin
            errors++; $display("FAIL press_same_cycle: got pend=%h evt=%0d want pend=1 evt=1", pending, evt_cnt);
        end
        checks++;
        if (gp_word !== 32'h0001_0101) begin
            errors++; $display("FAIL press_word: got %h want %h", gp_word, 32'h0001_0101);
        end
    endtask

    task automatic test_bounce;
        int bad = 0;
        for (int k = 0; k < 20; k++) begin
            sw_raw[1] = ~k[0];
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (gp_word !== 32'h0001_0101) bad++;
            end
        end
        sw_raw[1] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            step(1);
            if (gp_word !== 32'h0001_0101) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bounce_rejected: got %0d bad cycles want 0 (last word %h)", bad, gp_word);
        end
    endtask

    task automatic test_clear_vs_set;
        int n;
        int early = 0;
        sw_raw[2] = 1'b1;
        wait_state(4'h4, 4'h4, n);
        checks++;
        if (pending !== 4'h5 || evt_cnt !== 8'd2) begin
            errors++; $display("FAIL clr_setup: got pend=%h evt=%0d want 5 / 2", pending, evt_cnt);
        end
        clr = 4'h4;
        step(1);
        clr = 4'h0;
        checks++;
        if (pending !== 4'h1) begin
            errors++; $display("FAIL clr_pulse: got %h want %h", pending, 4'h1);
        end
        sw_raw[2] = 1'b0;
        wait_state(4'h4, 4'h0, n);
        checks++;
        if (n == 999 || pending !== 4'h1 || evt_cnt !== 8'd2) begin
            errors++; $display("FAIL fall_no_event: got n=%0d pend=%h evt=%0d want pend=1 evt=2", n, pending, evt_cnt);
        end
        // Clear held through the whole debounce, including the rise edge.
        clr = 4'h4;
        sw_raw[2] = 1'b1;
        n = 999;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (sw_state[2]) begin
                n = k;
                break;
            end
            if (pending[2]) early++;
        end
        clr = 4'h0;
        checks++;
        if (n == 999 || early != 0 || pending !== 4'h5 || evt_cnt !== 8'd3) begin
            errors++; $display("FAIL set_wins: got n=%0d early=%0d pend=%h evt=%0d want pend=5 evt=3", n, early, pending, evt_cnt);
        end
        step(1);
        checks++;
        if (pending !== 4'h5) begin
            errors++; $display("FAIL set_held: got %h want %h", pending, 4'h5);
        end
    endtask

    task automatic test_wrap;
        int n;
        int miss = 0;
        do_reset(4'h0);
        for (int k = 0; k < 256; k++) begin
            sw_raw[3] = 1'b1;
            wait_state(4'h8, 4'h8, n);
            if (n == 999) miss++;
            sw_raw[3] = 1'b0;
            wait_state(4'h8, 4'h0, n);
            if (n == 999) miss++;
        end
        checks++;
        if (miss != 0 || evt_cnt !== 8'd0) begin
            errors++; $display("FAIL wrap_256: got evt=%0d miss=%0d want evt=0 miss=0", evt_cnt, miss);
        end
        sw_raw[3] = 1'b1;
        wait_state(4'h8, 4'h8, n);
        checks++;
        if (n == 999 || evt_cnt !== 8'd1) begin
            errors++; $display("FAIL wrap_plus_one: got evt=%0d want 1", evt_cnt);
        end
        sw_raw[3] = 1'b0;
        wait_state(4'h8, 4'h0, n);
        checks++;
        if (n == 999 || evt_cnt !== 8'd1 || pending !== 4'h8) begin
            errors++; $display("FAIL wrap_release: got evt=%0d pend=%h want evt=1 pend=8", evt_cnt, pending);
        end
    endtask

    task automatic test_reset_mid_debounce;
        int n;
        do_reset(4'h0);
        step(5);
        sw_raw[0] = 1'b1;
        step(8);
        reset = 1'b0;
        #1;
        checks++;
        if (gp_word !== 32'h0) begin
            errors++; $display("FAIL mid_reset_word: got %h want %h", gp_word, 32'h0);
        end
        step(2);
        reset = 1'b1;
        wait_state(4'h1, 4'h1, n);
        checks++;
        if (n < 11 || n > 14) begin
            errors++; $display("FAIL mid_reset_latency: got %0d want 11..14", n);
        end
        checks++;
        if (gp_word !== 32'h0001_0101) begin
            errors++; $display("FAIL mid_reset_word_after: got %h want %h", gp_word, 32'h0001_0101);
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_clear_vs_set;
        test_wrap;
        test_reset_mid_debounce;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_input_capture.md
# gpio_input_capture

Input-side companion to the board display path: synchronises and debounces the raw board switches, detects press (rising) events, latches them as sticky pending flags, and counts them. It packs everything into the 32-bit general-purpose input word the SoC reads on `gpI1`. The SoC clears pending flags through a per-bit clear strobe taken from its general-purpose output.

## Interface
- `N_SW`, 4: number of switch inputs; legal range 1–8.
- `DIV`, 100000: system clocks per sample tick; must be ≥ 2.
- `STABLE`, 8: consecutive sample ticks a new level must persist before it is accepted; must be ≥ 1.

- `clk`  in  1  system clock (100 MHz on board); all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sw_raw`  in  N_SW  raw, asynchronous switch levels.
- `clr`  in  N_SW  level-sensitive pending-clear, one bit per switch, synchronous to `clk`.
- `sw_state`  out  N_SW  debounced switch levels.
- `pending`  out  N_SW  sticky rising-event flags.
- `evt_cnt`  out  8  running count of rising events, modulo 256.
- `gp_word`  out  32  packed SoC input word.

## Operation
- **Synchroniser:** 2-flop chain per bit: `sync = sw_raw` delayed by 2 `clk` cycles.
- **Prescaler:** counter `pc` runs 0..DIV-1 and wraps to 0. `tick` = (`pc` == DIV-1) and is one cycle wide.
- **Debounce**, per bit i, evaluated only on cycles where `tick` = 1:
  - `sync[i]` == `sw_state[i]`: `cnt[i]` ← 0.
  - `sync[i]` != `sw_state[i]` and `cnt[i]` < STABLE-1: `cnt[i]` ← `cnt[i]` + 1.
  - `sync[i]` != `sw_state[i]` and `cnt[i]` == STABLE-1: `sw_state[i]` ← `sync[i]` and `cnt[i]` ← 0.
  - Net effect: a level is accepted after STABLE consecutive differing ticks. Any agreeing tick restarts the count.
  - `cnt` width is clog2(STABLE), minimum 1 bit.
- **Rise detect:** `rise[i]` = 1 on the tick where `sw_state[i]` is about to change 0→1. Falling transitions generate no event.
- **Pending:** `pending[i]` next value = `rise[i]` | (`pending[i]` & ~`clr[i]`).
  - Set wins over a simultaneous clear.
  - Bits with `clr` = 0 are unaffected.
- **Event counter:** `evt_cnt` ← `evt_cnt` + popcount(`rise`), modulo 256. Several switches rising on the same tick add their full count.
- **Packing:**
  - `gp_word[N_SW-1:0]` = `sw_state`.
  - `gp_word[N_SW+7:8]` = `pending`.
  - `gp_word[23:16]` = `evt_cnt`.
  - All other bits = 0.
- **Reset (async, `reset` = 0):** `sync`, `pc`, `cnt`, `sw_state`, `pending` and `evt_cnt` all go to 0, so `gp_word` = 0 during reset.
  - A switch that is already high at reset release is seen as a rising event once it debounces. This is intentional.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- All outputs are registered. `gp_word` bits change in the same cycle as their source register.
- Clean input step to `sw_state` change: 2 (sync) + the time until the first tick + (STABLE-1)×DIV cycles.
  - Minimum: 2 + 1 + (STABLE-1)×DIV cycles.
  - Maximum: 2 + DIV + (STABLE-1)×DIV cycles.
- `pending[i]` and `evt_cnt` update in the same cycle as `sw_state[i]` rises.
- A `clr[i]` asserted on cycle k makes `pending[i]` = 0 from cycle k+1, unless `rise[i]` occurs on cycle k.
- Bounce rejection: any pulse or glitch shorter than (STABLE-1)×DIV cycles of the synchronised signal is never accepted.
- `evt_cnt` wraps from 255 to 0 without saturation or flag. With N_SW = 4 it can step by up to 4 in one cycle, wrapping modulo 256.

## Test plan
All scenarios use the sim parameters DIV=4, STABLE=3, N_SW=4.
- **Reset:** hold `reset` = 0 with `sw_raw` = 4'hF → `gp_word` = 0. Release reset, hold `sw_raw` constant → `sw_state` = 4'hF within 2+4+8 = 14 cycles, `pending` = 4'hF, `evt_cnt` = 4.
- **Clean press:** `sw_raw[0]` 0→1 and held → `sw_state[0]` rises between cycles 11 and 14 after the step, `pending[0]` = 1, `evt_cnt` +1, `gp_word` = 32'h0001_0101 starting from `evt_cnt` = 0.
- **Bounce:** toggle `sw_raw[1]` every 3 cycles for 60 cycles, then leave it at 0 → `sw_state[1]`, `pending[1]` and `evt_cnt` never change.
- **Clear vs. set:** with `pending[2]` = 1, pulse `clr[2]` for 1 cycle → `pending[2]` = 0 the next cycle. Then assert `clr[2]` on the exact cycle of a new rise → `pending[2]` stays 1.
- **Wrap:** drive 256 press/release cycles on `sw_raw[3]` → `evt_cnt` returns to 0. One more press → `evt_cnt` = 1. Release → `evt_cnt` unchanged.
- **Reset mid-debounce:** step `sw_raw[0]` high, assert `reset` 8 cycles later → all outputs 0 immediately. After release, the full 11–14 cycle latency is required again before `sw_state[0]` rises.
